axi_stream_dw_downsizer: RTL
============================

// Module: axi_stream_dw_downsizer
// PURPOSE
// Splits each wide AXI-Stream word into DataWidthIn/DataWidthOut narrow beats, LSB slice first.
// Downstream counterpart of the stream upsizer: it narrows the wide datapath back to a
// serial link (e.g. 32b core stream to 8b PHY/FIFO).
// Full-throughput: one narrow beat per cycle, no bubble between consecutive wide words.
// PARAMETERS
// DataWidthIn   32  input tdata width; integer multiple of DataWidthOut
// DataWidthOut   8  output tdata width; N = DataWidthIn/DataWidthOut, N >= 2
// IdWidth        1  tid width (>=1)
// DestWidth      1  tdest width (>=1)
// UserWidth      1  tuser width (>=1)
// PORTS
// clk_i        in   1             clock, all logic on rising edge
// rst_i        in   1             reset, synchronous, active-high
// in_tvalid_i  in   1             input word valid
// in_tready_o  out  1             input word accepted when in_tvalid_i & in_tready_o
// in_tdata_i   in   DataWidthIn   wide data
// in_tkeep_i   in   DataWidthIn/8 byte keep (used only with KEEP_TRIM)
// in_tlast_i   in   1             packet end
// in_tid_i / in_tdest_i / in_tuser_i  in  IdWidth/DestWidth/UserWidth  sideband
// out_tvalid_o out  1             narrow beat valid
// out_tready_i in   1             downstream ready
// out_tdata_o  out  DataWidthOut  slice idx of held word
// out_tkeep_o  out  DataWidthOut/8 keep slice idx
// out_tlast_o  out  1             set only on final emitted beat of a tlast word
// out_tid_o / out_tdest_o / out_tuser_o  out  sideband of held word, replicated per beat
// BEHAVIOUR
// - Reset (rst_i=1 at edge): state IDLE, idx=0, held word cleared; while rst_i=1:
//   out_tvalid_o=0, in_tready_o=0, out_tdata/tkeep/tlast/tid/tdest/tuser=0.
// - States: IDLE (no word held), SER (word held, emitting slice idx).
// - in_tready_o = IDLE | (SER & out_tready_i & idx==last_idx). Combinational, no rst path loop.
// - Input handshake: register whole word + sideband, idx<=0, state<=SER.
// - Latency: first narrow beat valid the cycle after input acceptance.
// - SER: out_tvalid_o=1; out_tdata_o = held[idx*DataWidthOut +: DataWidthOut].
//   On out handshake: idx<last_idx -> idx++; idx==last_idx -> if input handshake same cycle
//   load new word, idx<=0, stay SER; else state<=IDLE.
// - last_idx = N-1 (KEEP_TRIM variants below). idx counter width $clog2(N), never wraps past last_idx.
// - AXI rules: out_tvalid_o never drops without handshake; out_* stable while stalled.
// - out_tlast_o = held_tlast & (idx==last_idx); intermediate beats tlast=0.
// - Reset mid-word: held word discarded, no further beats; next word starts at slice 0.
// - Input stalls in SER do not affect output; input tvalid ignored while in_tready_o=0.
// CONFIGURATION
// AXI_STREAM_DW_DOWNSIZER_KEEP_TRIM_EN
// - defined: for a word with tlast=1, last_idx = highest slice with any in_tkeep bit set
//   (computed at load); trailing all-zero slices not emitted; tlast on that beat.
//   Word with tlast=1 and tkeep all zero: emit slice 0 only, with tlast (packet never lost).
//   Words with tlast=0 always emit N beats.
// - undefined: in_tkeep_i only forwarded; every word emits exactly N beats.
// TESTING (DataWidthIn=32, DataWidthOut=8, out_tready_i=1 unless stated)
// 1 word 32'hef563412 keep=4'hF tlast=0 -> beats 12,34,56,ef on 4 consecutive cycles, tlast=0 all.
// 2 same word tlast=1 -> tlast=1 only on beat ef; state IDLE after; in_tready_o=1 next cycle.
// 3 two words back-to-back, tvalid held -> 8 beats no gap; in_tready_o=1 only in 4th-beat cycle.
// 4 out_tready_i=0 for 3 cycles while showing beat 34 -> 34 held stable, then 56,ef; nothing lost.
// 5 word 32'h00ef3412 keep=4'b0111 tlast=1 -> macro on: 12,34,ef(tlast); off: 12,34,ef,00(tlast).
// 6 rst_i pulsed after 2 beats of a word -> out_tvalid_o=0 next cycle; next word begins at 12.

Source files
------------

// File: rtl/axi_stream_dw_downsizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_dw_downsizer_if
//  Description : AXI-Stream bundle (tvalid/tready/tdata/tkeep/tlast/sideband)
//                with master and slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_stream_dw_downsizer_if #(
    parameter int DataWidth = 32,
    parameter int IdWidth   = 1,
    parameter int DestWidth = 1,
    parameter int UserWidth = 1
);
    logic                   tvalid;
    logic                   tready;
    logic [DataWidth-1:0]   tdata;
    logic [DataWidth/8-1:0] tkeep;
    logic                   tlast;
    logic [IdWidth-1:0]     tid;
    logic [DestWidth-1:0]   tdest;
    logic [UserWidth-1:0]   tuser;

    modport master (
        output tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axi_stream_dw_downsizer.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_dw_downsizer
//  Description : Splits each wide AXI-Stream word into DataWidthIn/DataWidthOut
//                narrow beats, LSB slice first, at one beat per cycle.
//                Optional macro AXI_STREAM_DW_DOWNSIZER_KEEP_TRIM_EN drops the
//                trailing all-zero-keep slices of a tlast word.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_dw_downsizer #(
    parameter int DataWidthIn  = 32,
    parameter int DataWidthOut = 8,
    parameter int IdWidth      = 1,
    parameter int DestWidth    = 1,
    parameter int UserWidth    = 1
) (
    input  wire                       clk_i,
    input  wire                       rst_i,
    axi_stream_dw_downsizer_if.slave  in_if,
    axi_stream_dw_downsizer_if.master out_if
);

    localparam int N        = DataWidthIn / DataWidthOut;
    localparam int IdxW     = $clog2(N);
    localparam int KeepInW  = DataWidthIn / 8;
    localparam int KeepOutW = DataWidthOut / 8;

    localparam logic [IdxW-1:0] c_max_idx = IdxW'(N - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SER  = 1'b1
    } state_e;

    state_e                 state_q,    state_d;
    logic [IdxW-1:0]        idx_q,      idx_d;
    logic [IdxW-1:0]        last_idx_q, last_idx_d;
    logic [DataWidthIn-1:0] data_q,     data_d;
    logic [KeepInW-1:0]     keep_q,     keep_d;
    logic                   tlast_q,    tlast_d;
    logic [IdWidth-1:0]     tid_q,      tid_d;
    logic [DestWidth-1:0]   tdest_q,    tdest_d;
    logic [UserWidth-1:0]   tuser_q,    tuser_d;

    logic                   w_emit;
    logic                   w_at_last;
    logic                   w_out_hs;
    logic                   w_in_ready;
    logic                   w_in_hs;
    logic [IdxW-1:0]        w_load_last_idx;

    // Reset gates every output combinationally so nothing leaks before the first edge.
    assign w_emit     = !rst_i && (state_q == S_SER);
    assign w_at_last  = (idx_q == last_idx_q);
    assign w_out_hs   = w_emit && out_if.tready;
    assign w_in_ready = !rst_i && ((state_q == S_IDLE) || (w_out_hs && w_at_last));
    assign w_in_hs    = w_in_ready && in_if.tvalid;

`ifdef AXI_STREAM_DW_DOWNSIZER_KEEP_TRIM_EN
    // A tlast word ends at its highest slice carrying any keep bit; all-zero keeps slice 0.
    always_comb begin
        w_load_last_idx = c_max_idx;
        if (in_if.tlast) begin
            w_load_last_idx = '0;
            for (int s = 0; s < N; s++) begin
                if (|in_if.tkeep[s*KeepOutW +: KeepOutW]) begin
                    w_load_last_idx = IdxW'(s);
                end
            end
        end
    end
`else
    assign w_load_last_idx = c_max_idx;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        data_d     = data_q;
        keep_d     = keep_q;
        tlast_d    = tlast_q;
        tid_d      = tid_q;
        tdest_d    = tdest_q;
        tuser_d    = tuser_q;

        case (state_q)
            S_IDLE: begin
                if (w_in_hs) begin
                    state_d = S_SER;
                end
            end
            S_SER: begin
                if (w_out_hs) begin
                    if (!w_at_last) begin
                        idx_d = idx_q + 1'b1;
                    end else if (!w_in_hs) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Loading is shared by the idle start and the back-to-back refill.
        if (w_in_hs) begin
            idx_d      = '0;
            last_idx_d = w_load_last_idx;
            data_d     = in_if.tdata;
            keep_d     = in_if.tkeep;
            tlast_d    = in_if.tlast;
            tid_d      = in_if.tid;
            tdest_d    = in_if.tdest;
            tuser_d    = in_if.tuser;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_idx_q <= c_max_idx;
            data_q     <= '0;
            keep_q     <= '0;
            tlast_q    <= 1'b0;
            tid_q      <= '0;
            tdest_q    <= '0;
            tuser_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            tlast_q    <= tlast_d;
            tid_q      <= tid_d;
            tdest_q    <= tdest_d;
            tuser_q    <= tuser_d;
        end
    end

    assign in_if.tready  = w_in_ready;
    assign out_if.tvalid = w_emit;
    assign out_if.tdata  = w_emit ? data_q[idx_q*DataWidthOut +: DataWidthOut] : '0;
    assign out_if.tkeep  = w_emit ? keep_q[idx_q*KeepOutW +: KeepOutW] : '0;
    assign out_if.tlast  = w_emit && tlast_q && w_at_last;
    assign out_if.tid    = w_emit ? tid_q   : '0;
    assign out_if.tdest  = w_emit ? tdest_q : '0;
    assign out_if.tuser  = w_emit ? tuser_q : '0;

endmodule
`default_nettype wire
